// File: rtl/req_arbiter_pkg.sv
// Shared types and defaults for the request arbiter slice (package arb_pkg).
package arb_pkg;

  localparam int N_REQ_DEF = 16;
  localparam int IDW_DEF   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef logic [N_REQ_DEF-1:0] req_vec_t;
  typedef logic [IDW_DEF-1:0]   gnt_id_t;

endpackage

// File: rtl/req_arbiter_pick.sv
// req_pick: combinational descending wrap-around search for the first set
// request bit, starting at i_start.
module req_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDW   = IDW_DEF
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDW-1:0]   i_start,
  output logic             o_hit,
  output logic [IDW-1:0]   o_idx,
  output logic [N_REQ-1:0] o_onehot
);

  logic [IDW-1:0] w_cand;

  // NOTE: every output gets a default before the loop so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    o_hit    = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    w_cand   = '0;
    // N_REQ is a power of two, so IDW-bit subtraction wraps modulo N_REQ.
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = i_start - IDW'(k);
      if (!o_hit && i_req[w_cand]) begin
        o_hit = 1'b1;
        o_idx = w_cand;
      end
    end
    o_onehot[o_idx] = o_hit;
  end

endmodule

// File: rtl/req_arbiter.sv
// req_arbiter: registered 1-of-N_REQ grant with hold-time timeout.
// Define ROUND_ROBIN_EN for rotating priority; default is fixed highest-index.
module req_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int IDW      = IDW_DEF,
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic             gnt_valid,
  output logic [IDW-1:0]   gnt_id,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic             busy,
  output logic             timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [7:0] HOLD_SAT  = 8'(MAX_HOLD);

  arb_state_t       r_state;
  logic [7:0]       r_hold;
  logic [IDW-1:0]   r_last;
  logic             r_gnt_valid;
  logic [IDW-1:0]   r_gnt_id;
  logic [N_REQ-1:0] r_gnt_onehot;
  logic             r_timeout;

  logic [IDW-1:0]   w_start;
  logic             w_hit;
  logic [IDW-1:0]   w_idx;
  logic [N_REQ-1:0] w_onehot;
  logic             w_owner_req;
  logic             w_expired;
  logic             w_release;

`ifdef ROUND_ROBIN_EN
  assign w_start = r_last - IDW'(1);
`else
  // last_gnt is still tracked; masking it keeps the start pinned at the top.
  assign w_start = IDW'(N_REQ - 1) | (r_last & IDW'(0));
`endif

  req_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_pick (
    .i_req    (req),
    .i_start  (w_start),
    .o_hit    (w_hit),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

  assign w_owner_req = |(req & r_gnt_onehot);
  assign w_expired   = (r_hold == HOLD_LAST);
  assign w_release   = done || !w_owner_req || w_expired;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and simulation matches the synthesized hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_hold       <= '0;
      r_last       <= '0;
      r_gnt_valid  <= 1'b0;
      r_gnt_id     <= '0;
      r_gnt_onehot <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_state      <= GRANT;
            r_hold       <= '0;
            r_gnt_valid  <= 1'b1;
            r_gnt_id     <= w_idx;
            r_gnt_onehot <= w_onehot;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_last       <= r_gnt_id;
            r_gnt_valid  <= 1'b0;
            r_gnt_id     <= '0;
            r_gnt_onehot <= '0;
            // Pulse only when the counter alone forced the release.
            r_timeout    <= w_expired && !done && w_owner_req;
          end else if (r_hold != HOLD_SAT) begin
            r_hold <= r_hold + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt_valid  = r_gnt_valid;
  assign gnt_id     = r_gnt_id;
  assign gnt_onehot = r_gnt_onehot;
  assign busy       = (r_state != IDLE);
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_req_arbiter.sv
// Scoreboard bench for req_arbiter: directed vectors push expected outputs,
// a negedge monitor pops and compares them. Honors ROUND_ROBIN_EN.
module tb_req_arbiter;

  localparam int N_REQ    = 16;
  localparam int IDW      = 4;
  localparam int MAX_HOLD = 15;
`ifdef ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [N_REQ-1:0] req;
  logic             done;
  logic             gnt_valid;
  logic [IDW-1:0]   gnt_id;
  logic [N_REQ-1:0] gnt_onehot;
  logic             busy;
  logic             timeout;

  typedef struct {
    logic             valid;
    logic [IDW-1:0]   id;
    logic [N_REQ-1:0] onehot;
    logic             busy;
    logic             to;
    string            tag;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  req_arbiter #(
    .N_REQ    (N_REQ),
    .IDW      (IDW),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id),
    .gnt_onehot (gnt_onehot),
    .busy       (busy),
    .timeout    (timeout)
  );

  // Monitor: compare whenever an expectation is pending for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if ({gnt_valid, gnt_id, gnt_onehot, busy, timeout} !==
            {e.valid, e.id, e.onehot, e.busy, e.to}) begin
          n_err++;
          $display("FAIL %s: got valid=%b id=%0d onehot=%h busy=%b timeout=%b, want valid=%b id=%0d onehot=%h busy=%b timeout=%b",
                   e.tag, gnt_valid, gnt_id, gnt_onehot, busy, timeout,
                   e.valid, e.id, e.onehot, e.busy, e.to);
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic cyc(input logic r, input logic [N_REQ-1:0] rq, input logic d,
                     input logic ev, input int eid, input logic eto, input string tag);
    exp_t e;
    rst  = r;
    req  = rq;
    done = d;
    @(posedge clk);
    e.valid  = ev;
    e.id     = ev ? IDW'(eid) : '0;
    e.onehot = ev ? (N_REQ'(1) << eid) : '0;
    e.busy   = ev;
    e.to     = eto;
    e.tag    = tag;
    q.push_back(e);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    req  = 16'hFFFF;
    done = 1'b0;

    // Reset with all requests held, then highest index wins.
    cyc(1, 16'hFFFF, 0, 0, 0,  0, "reset_all_req");
    cyc(0, 16'hFFFF, 0, 1, 15, 0, "first_grant_15");
    cyc(0, 16'hFFFF, 1, 0, 0,  0, "done_release_15");
    cyc(0, 16'h0000, 1, 0, 0,  0, "idle_done_ignored");

    // 0x0011, done in 3rd grant cycle, then re-arbitrate after a bubble.
    cyc(0, 16'h0011, 0, 1, 4, 0, "g4_cycle1");
    cyc(0, 16'h0011, 0, 1, 4, 0, "g4_cycle2");
    cyc(0, 16'h0011, 0, 1, 4, 0, "g4_cycle3");
    cyc(0, 16'h0011, 1, 0, 0, 0, "g4_done_drop");
    cyc(0, 16'h0011, 0, 1, RR ? 0 : 4, 0, "after_bubble_0011");
    cyc(0, 16'h0011, 1, 0, 0, 0, "release_0011");
    cyc(0, 16'h0000, 0, 0, 0, 0, "idle_0");

    // 0x0100 held with no done: forced release after MAX_HOLD cycles.
    cyc(0, 16'h0100, 0, 1, 8, 0, "g8_cycle1");
    for (int i = 0; i < MAX_HOLD - 1; i++) cyc(0, 16'h0100, 0, 1, 8, 0, "g8_hold");
    cyc(0, 16'h0100, 0, 0, 0, 1, "g8_timeout_pulse");
    cyc(0, 16'h0000, 0, 0, 0, 0, "g8_pulse_ends");

    // Owner 9 keeps the grant while 12 rises; withdrawal hands over to 12.
    cyc(0, 16'h0200, 1, 1, 9,  0, "g9_done_in_idle");
    cyc(0, 16'h1200, 0, 1, 9,  0, "g9_frozen_a");
    cyc(0, 16'h1200, 0, 1, 9,  0, "g9_frozen_b");
    cyc(0, 16'h1000, 0, 0, 0,  0, "g9_withdraw");
    cyc(0, 16'h1000, 0, 1, 12, 0, "g12_after_bubble");
    cyc(0, 16'h1000, 1, 0, 0,  0, "g12_release");
    cyc(0, 16'h0000, 0, 0, 0,  0, "idle_1");

    // Reset during the 5th grant cycle together with done.
    cyc(0, 16'h0040, 0, 1, 6, 0, "g6_cycle1");
    for (int i = 0; i < 4; i++) cyc(0, 16'h0040, 0, 1, 6, 0, "g6_hold");
    cyc(1, 16'h0040, 1, 0, 0, 0, "g6_reset_mid_grant");

    // 0x8001 alternation (rotating) or 15 every time (fixed).
    cyc(0, 16'h8001, 0, 1, 15, 0, "alt_g1");
    cyc(0, 16'h8001, 1, 0, 0,  0, "alt_r1");
    cyc(0, 16'h8001, 0, 1, RR ? 0 : 15, 0, "alt_g2");
    cyc(0, 16'h8001, 1, 0, 0,  0, "alt_r2");
    cyc(0, 16'h8001, 0, 1, 15, 0, "alt_g3");

    // Reset on the cycle the timeout would fire: no pulse, search restarts at 15.
    for (int i = 0; i < MAX_HOLD - 1; i++) cyc(0, 16'h8001, 0, 1, 15, 0, "alt_g3_hold");
    cyc(1, 16'h8001, 0, 0, 0,  0, "reset_on_timeout");
    cyc(0, 16'h8001, 0, 1, 15, 0, "restart_at_15");
    cyc(0, 16'h8001, 1, 0, 0,  0, "final_release");
    cyc(0, 16'h0000, 0, 0, 0,  0, "final_idle");

    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
